// File: rtl/svnes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : svnes_pkg
//  Purpose  : Shared types and constants for the CPU-side bus blocks.
//             Holds the sprite-DMA state encoding, the bus-source select
//             encoding and the fixed register addresses.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package svnes_pkg;

   // Sprite DMA controller states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } dma_state_t;

   // Which master drives the system bus this cycle
   typedef enum logic [1:0] {
      SEL_CPU   = 2'd0,   // straight pass-through
      SEL_DUMMY = 2'd1,   // CPU address/data, direction forced to read
      SEL_DMA   = 2'd2    // DMA engine owns the bus
   } bus_sel_t;

   localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage
`default_nettype wire

// File: rtl/oam_dma_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module   : bus_mux
//  Purpose  : Three-way select of system bus address / write data / direction
//             among the CPU, a CPU-addressed dummy read, and the DMA engine.
//  Ports    : i_sel                  bus source select (bus_sel_t encoding)
//             i_cpu_addr/wdata/rw    CPU side of the bus
//             i_dma_addr/wdata/rw    DMA engine side of the bus
//             o_addr/o_wdata/o_rw    system bus outputs
//  Revision : 1.0  initial release
// ============================================================================
module bus_mux
   import svnes_pkg::*;
(
   input  logic [1:0]  i_sel,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_wdata,
   input  logic        i_cpu_rw,
   input  logic [15:0] i_dma_addr,
   input  logic [7:0]  i_dma_wdata,
   input  logic        i_dma_rw,
   output logic [15:0] o_addr,
   output logic [7:0]  o_wdata,
   output logic        o_rw
);

   always_comb begin
      o_addr  = i_cpu_addr;
      o_wdata = i_cpu_wdata;
      o_rw    = i_cpu_rw;
      case (bus_sel_t'(i_sel))
         // A halted CPU keeps presenting its address; the cycle is turned
         // into a harmless read so a pending CPU write is never committed.
         SEL_DUMMY: o_rw = 1'b1;
         SEL_DMA: begin
            o_addr  = i_dma_addr;
            o_wdata = i_dma_wdata;
            o_rw    = i_dma_rw;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma
//  Purpose  : Sprite DMA controller and bus owner between the CPU core and
//             the system bus. A CPU write to TRIG_ADDR halts the CPU and
//             copies the 256-byte page $PP00-$PPFF to DST_ADDR using
//             alternating read/write cycles. When idle the CPU bus passes
//             straight through.
//  Ports    : clk         CPU-rate clock
//             reset       synchronous, active-high
//             cpu_addr    CPU address
//             cpu_wdata   CPU write data
//             cpu_rw      CPU direction (1 = read)
//             rdy         1 = CPU may advance, 0 = CPU stalled
//             bus_addr    system bus address
//             bus_wdata   system bus write data
//             bus_rw      system bus direction (1 = read)
//             bus_rdata   system bus read data
//             dma_active  high whenever a transfer is in progress
//  Revision : 1.0  initial release
// ============================================================================
module oam_dma
   import svnes_pkg::*;
#(
   parameter logic [15:0] TRIG_ADDR = OAMDMA_ADDR,
   parameter logic [15:0] DST_ADDR  = OAMDATA_ADDR,
   parameter int          LEN       = 256
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_rw,
   output logic        rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_rw,
   input  logic [7:0]  bus_rdata,
   output logic        dma_active
);

   // Index of the final byte; the counter is 8 bits so LEN must be 256.
   localparam logic [7:0] c_LAST_IDX = 8'(LEN - 1);

   dma_state_t  r_state;
   dma_state_t  w_state_nxt;
   logic        r_phase;      // 0 = get cycle, 1 = put cycle
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [7:0]  r_page;
   logic [7:0]  w_page_nxt;
   logic [7:0]  r_buf;
   logic [7:0]  w_buf_nxt;

   logic        w_trig;
   logic [1:0]  w_sel;
   logic [15:0] w_dma_addr;
   logic [7:0]  w_dma_wdata;
   logic        w_dma_rw;

   assign w_trig = !cpu_rw && (cpu_addr == TRIG_ADDR);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_phase <= 1'b0;
         r_cnt   <= 8'h00;
         r_page  <= 8'h00;
         r_buf   <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= ~r_phase;
         r_cnt   <= w_cnt_nxt;
         r_page  <= w_page_nxt;
         r_buf   <= w_buf_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state, datapath update and bus ownership
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_page_nxt  = r_page;
      w_buf_nxt   = r_buf;
      w_sel       = SEL_CPU;
      w_dma_addr  = {r_page, r_cnt};
      w_dma_wdata = r_buf;
      w_dma_rw    = 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (w_trig) begin
               w_page_nxt  = cpu_wdata;
               w_cnt_nxt   = 8'h00;
               w_state_nxt = ST_HALT;
            end
         end

         ST_HALT: begin
            w_sel = SEL_DUMMY;
            // The phase flips at the coming edge, so a put cycle now means
            // the next cycle is a get cycle and READ can start immediately.
            w_state_nxt = r_phase ? ST_READ : ST_ALIGN;
         end

         ST_ALIGN: begin
            w_sel       = SEL_DUMMY;
            w_state_nxt = ST_READ;
         end

         ST_READ: begin
            w_sel       = SEL_DMA;
            w_dma_addr  = {r_page, r_cnt};
            w_dma_rw    = 1'b1;
            w_buf_nxt   = bus_rdata;
            w_state_nxt = ST_WRITE;
         end

         ST_WRITE: begin
            w_sel       = SEL_DMA;
            w_dma_addr  = DST_ADDR;
            w_dma_rw    = 1'b0;
            w_dma_wdata = r_buf;
            // Wraps back to zero only on the final byte, so the source
            // address never leaves the page.
            w_cnt_nxt   = r_cnt + 8'd1;
            w_state_nxt = (r_cnt == c_LAST_IDX) ? ST_IDLE : ST_READ;
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign rdy        = (r_state == ST_IDLE);
   assign dma_active = (r_state != ST_IDLE);

   bus_mux u_bus_mux (
      .i_sel       (w_sel),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_wdata (cpu_wdata),
      .i_cpu_rw    (cpu_rw),
      .i_dma_addr  (w_dma_addr),
      .i_dma_wdata (w_dma_wdata),
      .i_dma_rw    (w_dma_rw),
      .o_addr      (bus_addr),
      .o_wdata     (bus_wdata),
      .o_rw        (bus_rw)
   );

endmodule
`default_nettype wire
